// File: rtl/cluster_packer_pkg.sv
// Shared definitions for the iterative cluster packer.
//   - geometry constants (S-bits per VFAT, VFAT count, rows, field widths)
//   - cluster_t {cnt, adr} slot record and INVALID_ADR filler address
//   - state_t FSM encoding used by cluster_packer_iter
package cluster_packer_pkg;

  localparam int unsigned MXSBITS    = 64;
  localparam int unsigned NVFATS     = 24;
  localparam int unsigned MXROWS     = 8;
  localparam int unsigned MXCNTBITS  = 3;
  localparam int unsigned MXADRBITS  = 11;
  localparam int unsigned MXCLUSTERS = 8;

  localparam int unsigned MXKEYS = NVFATS * MXSBITS / MXROWS;
  localparam int unsigned MXPADS = NVFATS * MXSBITS;
  localparam int unsigned CLW    = MXCNTBITS + MXADRBITS;

  localparam logic [MXADRBITS-1:0] INVALID_ADR = '1;

  typedef struct packed {
    logic [MXCNTBITS-1:0] cnt;
    logic [MXADRBITS-1:0] adr;
  } cluster_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COUNT,
    ST_ENCODE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/cluster_count_row.sv
// Combinational cluster-start (vpf) and size detection for one eta row.
// The row is treated as zero-padded at both ends so clusters never leak
// into a neighbouring row.
//   sbits_i  one row of S-bits, key 0 in bit 0
//   split_i  1 = split long clusters into full 2^MXCNTBITS-strip chunks
//   vpf_o    cluster-start flag per key
//   cnt_o    cluster size - 1 per key, saturating
// Optional feature macro: CLUSTER_PACKER_SPLIT_EN builds the split logic;
// without it split_i is ignored and clusters are always truncated.
module cluster_count_row
  import cluster_packer_pkg::*;
#(
  parameter int unsigned KEYS = MXKEYS
) (
  input  logic                           split_i,
  input  logic [KEYS-1:0]                sbits_i,
  output logic [KEYS-1:0]                vpf_o,
  output logic [KEYS-1:0][MXCNTBITS-1:0] cnt_o
);

  localparam int unsigned CHUNK = 1 << MXCNTBITS;
  localparam int unsigned LO    = CHUNK + 1;

  // Key k lives at pad[k+LO]; pad[k] is key k-CHUNK-1.
  logic [KEYS+LO+CHUNK-2:0] pad;
  assign pad = {{(CHUNK-1){1'b0}}, sbits_i, {LO{1'b0}}};

`ifndef CLUSTER_PACKER_SPLIT_EN
  logic unused_split;
  assign unused_split = ^{split_i, pad[CHUNK-1:0]};
`endif

  // NOTE: every output gets a default before the loop so no path can leave a
  // bit unassigned, which would otherwise infer a latch.
  always_comb begin
    logic run;
    run   = 1'b0;
    vpf_o = '0;
    cnt_o = '0;
    for (int k = 0; k < int'(KEYS); k++) begin
      vpf_o[k] = pad[k+LO] & ~pad[k+LO-1];
`ifdef CLUSTER_PACKER_SPLIT_EN
      // Second chunk starts exactly CHUNK strips into a cluster; the hit
      // itself must be present so an exactly-CHUNK cluster is not split.
      if (split_i && pad[k+LO] && (&pad[k+LO-1 -: CHUNK]) && !pad[k])
        vpf_o[k] = 1'b1;
`endif
      run = 1'b1;
      for (int j = 1; j < int'(CHUNK); j++) begin
        run = run & pad[k+LO+j];
        if (run) cnt_o[k] = cnt_o[k] + MXCNTBITS'(1);
      end
    end
  end

endmodule

// File: rtl/cluster_packer_iter.sv
// Iterative cluster packer: latches one frame of VFAT S-bits, remaps them
// into eta rows, finds cluster starts/sizes, then extracts up to MXCLUSTERS
// clusters with one priority-encode per cycle.
//   clock4x / global_reset_n   clock, async active-low reset
//   truncate_clusters          1 = truncate, 0 = split (sampled at accept)
//   reverse_priority_order     1 = highest address first (sampled at accept)
//   sbits_i / sbits_valid_i / sbits_ready_o   frame handshake
//   clusters_o / cluster_vld_o / overflow_o   packed result, slot 0 in LSBs
//   done_o                     one-cycle pulse when results update
// Optional feature macro: CLUSTER_PACKER_SPLIT_EN enables split mode.
module cluster_packer_iter
  import cluster_packer_pkg::*;
(
  input  logic                         clock4x,
  input  logic                         global_reset_n,
  input  logic                         truncate_clusters,
  input  logic                         reverse_priority_order,
  input  logic [MXPADS-1:0]            sbits_i,
  input  logic                         sbits_valid_i,
  output logic                         sbits_ready_o,
  output logic [MXCLUSTERS*CLW-1:0]    clusters_o,
  output logic [MXCLUSTERS-1:0]        cluster_vld_o,
  output logic                         overflow_o,
  output logic                         done_o
);

  localparam int unsigned IDXW = $clog2(MXCLUSTERS);

  state_t                        state_q;
  logic                          ready_q, done_q, ovf_q;
  logic                          trunc_q, rev_q;
  logic [IDXW-1:0]               idx_q;
  cluster_t [MXCLUSTERS-1:0]     out_q, slots_q;
  logic [MXCLUSTERS-1:0]         vld_out_q, slot_vld_q;

  logic [MXPADS-1:0]                 sbits_q, pads, vpf_c, vpf_q;
  logic [MXPADS-1:0][MXCNTBITS-1:0]  cnt_c, cnt_q;
  logic                              hit;
  logic [MXADRBITS-1:0]              hit_adr;

  // VFAT v lands in row v%MXROWS at key offset (v/MXROWS)*MXSBITS.
  for (genvar v = 0; v < NVFATS; v++) begin : g_remap
    assign pads[(v % MXROWS)*MXKEYS + (v / MXROWS)*MXSBITS +: MXSBITS] =
      sbits_q[v*MXSBITS +: MXSBITS];
  end

  for (genvar r = 0; r < MXROWS; r++) begin : g_row
    cluster_count_row #(.KEYS(MXKEYS)) u_row (
      .split_i (~trunc_q),
      .sbits_i (pads [r*MXKEYS +: MXKEYS]),
      .vpf_o   (vpf_c[r*MXKEYS +: MXKEYS]),
      .cnt_o   (cnt_c[r*MXKEYS +: MXKEYS])
    );
  end

  // Priority encoder over the remaining mask; the last match in scan order
  // wins, so scanning downward yields the lowest address.
  always_comb begin
    hit     = 1'b0;
    hit_adr = '0;
    if (rev_q) begin
      for (int i = 0; i < int'(MXPADS); i++)
        if (vpf_q[i]) begin hit = 1'b1; hit_adr = MXADRBITS'(i); end
    end else begin
      for (int i = int'(MXPADS) - 1; i >= 0; i--)
        if (vpf_q[i]) begin hit = 1'b1; hit_adr = MXADRBITS'(i); end
    end
  end

  // NOTE: frame, mask and slot registers carry no reset: each is fully
  // written by the FSM before it is read, and reset only has to return the
  // control state and the visible outputs.
  always_ff @(posedge clock4x) begin
    if (state_q == ST_IDLE && sbits_valid_i) sbits_q <= sbits_i;
    if (state_q == ST_COUNT) begin
      vpf_q <= vpf_c;
      cnt_q <= cnt_c;
    end
    if (state_q == ST_ENCODE) begin
      if (hit) begin
        vpf_q[hit_adr]     <= 1'b0;
        slots_q[idx_q]     <= '{cnt: cnt_q[hit_adr], adr: hit_adr};
        slot_vld_q[idx_q]  <= 1'b1;
      end else begin
        slots_q[idx_q]     <= '{cnt: '0, adr: INVALID_ADR};
        slot_vld_q[idx_q]  <= 1'b0;
      end
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q   <= ST_IDLE;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
      trunc_q   <= 1'b1;
      rev_q     <= 1'b0;
      idx_q     <= '0;
      vld_out_q <= '0;
      for (int i = 0; i < int'(MXCLUSTERS); i++)
        out_q[i] <= '{cnt: '0, adr: INVALID_ADR};
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (sbits_valid_i) begin
            trunc_q <= truncate_clusters;
            rev_q   <= reverse_priority_order;
            ready_q <= 1'b0;
            state_q <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          idx_q   <= '0;
          state_q <= ST_ENCODE;
        end
        ST_ENCODE: begin
          idx_q <= idx_q + IDXW'(1);
          if (idx_q == IDXW'(MXCLUSTERS - 1)) state_q <= ST_DONE;
        end
        ST_DONE: begin
          out_q     <= slots_q;
          vld_out_q <= slot_vld_q;
          ovf_q     <= |vpf_q;
          done_q    <= 1'b1;
          ready_q   <= 1'b1;
          state_q   <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sbits_ready_o = ready_q;
  assign clusters_o    = out_q;
  assign cluster_vld_o = vld_out_q;
  assign overflow_o    = ovf_q;
  assign done_o        = done_q;

endmodule

// File: tb/tb_cluster_packer_iter.sv
// Self-checking bench for cluster_packer_iter: directed table of frames with
// hand-derived expectations, randomized frames against a run-length model,
// and a mid-frame reset sequence. Honours CLUSTER_PACKER_SPLIT_EN.
module tb_cluster_packer_iter;
  import cluster_packer_pkg::*;

  localparam int LAT = MXCLUSTERS + 3;

  logic                      clk = 1'b0;
  logic                      rst_n = 1'b0;
  logic                      truncate = 1'b1;
  logic                      reverse = 1'b0;
  logic [MXPADS-1:0]         sbits = '0;
  logic                      valid = 1'b0;
  logic                      ready;
  logic [MXCLUSTERS*CLW-1:0] clusters;
  logic [MXCLUSTERS-1:0]     vld;
  logic                      ovf;
  logic                      done;

  cluster_packer_iter dut (
    .clock4x                (clk),
    .global_reset_n         (rst_n),
    .truncate_clusters      (truncate),
    .reverse_priority_order (reverse),
    .sbits_i                (sbits),
    .sbits_valid_i          (valid),
    .sbits_ready_o          (ready),
    .clusters_o             (clusters),
    .cluster_vld_o          (vld),
    .overflow_o             (ovf),
    .done_o                 (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [MXCLUSTERS*CLW-1:0] act,
                       input logic [MXCLUSTERS*CLW-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    string             name;
    logic [MXPADS-1:0] f;
    bit                tr;
    bit                rv;
    int                nv;
    int                a0, c0, a1, c1;
    bit                ov;
  } vec_t;
  vec_t vecs[$];

  task automatic add_vec(input string nm, input logic [MXPADS-1:0] f, input bit tr,
                         input bit rv, input int nv, input int a0, input int c0,
                         input int a1, input int c1, input bit ov);
    vec_t e;
    e.name = nm; e.f = f; e.tr = tr; e.rv = rv; e.nv = nv;
    e.a0 = a0; e.c0 = c0; e.a1 = a1; e.c1 = c1; e.ov = ov;
    vecs.push_back(e);
  endtask

  function automatic logic [MXPADS-1:0] run_bits(input int v, input int lo, input int hi);
    logic [MXPADS-1:0] r;
    r = '0;
    for (int b = lo; b <= hi; b++) r[v*MXSBITS + b] = 1'b1;
    return r;
  endfunction

  function automatic logic [MXCLUSTERS*CLW-1:0] reset_clusters();
    logic [MXCLUSTERS*CLW-1:0] r;
    for (int i = 0; i < int'(MXCLUSTERS); i++) r[i*CLW +: CLW] = {3'b000, 11'h7FF};
    return r;
  endfunction

  // Reference: walk each row's runs of hits; a run of length L yields a
  // cluster at its start with size min(L,8)-1, and in split mode a second
  // chunk 8 strips later when L>8. Then take clusters in address order.
  task automatic model(input logic [MXPADS-1:0] f, input bit split, input bit rv,
                       output logic [MXCLUSTERS*CLW-1:0] e_cl,
                       output logic [MXCLUSTERS-1:0] e_vld, output logic e_ovf);
    bit s [MXROWS][MXKEYS];
    bit has [MXPADS];
    int cn [MXPADS];
    int order [$];
    int k, st, len, a;
    for (int v = 0; v < int'(NVFATS); v++)
      for (int b = 0; b < int'(MXSBITS); b++)
        s[v % MXROWS][(v / MXROWS) * MXSBITS + b] = f[v*MXSBITS + b];
    for (int p = 0; p < int'(MXPADS); p++) begin has[p] = 0; cn[p] = 0; end
    for (int r = 0; r < int'(MXROWS); r++) begin
      k = 0;
      while (k < int'(MXKEYS)) begin
        if (s[r][k]) begin
          st = k;
          while (k < int'(MXKEYS) && s[r][k]) k++;
          len = k - st;
          a = r * MXKEYS + st;
          has[a] = 1; cn[a] = (len > 8 ? 8 : len) - 1;
          if (split && len > 8) begin
            has[a+8] = 1; cn[a+8] = (len - 8 > 8 ? 8 : len - 8) - 1;
          end
        end else k++;
      end
    end
    for (int p = 0; p < int'(MXPADS); p++)
      if (has[p]) begin
        if (rv) order.push_front(p); else order.push_back(p);
      end
    e_cl  = reset_clusters();
    e_vld = '0;
    for (int i = 0; i < int'(MXCLUSTERS) && i < order.size(); i++) begin
      e_cl[i*CLW +: CLW] = {cn[order[i]][2:0], order[i][10:0]};
      e_vld[i] = 1'b1;
    end
    e_ovf = order.size() > int'(MXCLUSTERS);
  endtask

  function automatic bit eff_split(input bit tr);
`ifdef CLUSTER_PACKER_SPLIT_EN
    return !tr;
`else
    return 1'b0 & tr;
`endif
  endfunction

  // Offers one frame and returns the cycle (relative to accept) where done_o
  // rose, or -1 if it did not within the budget.
  task automatic run_frame(input logic [MXPADS-1:0] f, input bit tr, input bit rv,
                           output int lat);
    int w;
    w = 0;
    while (!ready && w < 50) begin @(posedge clk); #1; w++; end
    check("ready_before_accept", ready, 1);
    sbits = f; truncate = tr; reverse = rv; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; sbits = '0;
    check("ready_low_after_accept", ready, 0);
    lat = -1;
    for (int c = 1; c <= 3 * LAT; c++) begin
      if (done) begin lat = c; break; end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_model(input string nm, input logic [MXPADS-1:0] f,
                             input bit tr, input bit rv);
    logic [MXCLUSTERS*CLW-1:0] e_cl;
    logic [MXCLUSTERS-1:0]     e_vld;
    logic                      e_ovf;
    model(f, eff_split(tr), rv, e_cl, e_vld, e_ovf);
    check({nm, "_clusters"}, clusters, e_cl);
    check({nm, "_vld"}, vld, e_vld);
    check({nm, "_ovf"}, ovf, e_ovf);
  endtask

  initial begin
    logic [MXPADS-1:0] f;
    int lat, nruns, row, key, len;
    bit tr, rv, saw_done;

    // Reset values, during and right after reset.
    #23;
    check("rst_ready", ready, 1);
    check("rst_done", done, 0);
    check("rst_ovf", ovf, 0);
    check("rst_vld", vld, 0);
    check("rst_clusters", clusters, reset_clusters());
    rst_n = 1'b1;
    #1;
    check("ready_after_release", ready, 1);
    @(posedge clk); #1;

    // Directed table.
    add_vec("single", run_bits(0, 5, 5), 1, 0, 1, 5, 0, 2047, 0, 0);
    add_vec("three", run_bits(1, 10, 12), 1, 0, 1, 202, 2, 2047, 0, 0);
    add_vec("v16_v17", run_bits(16, 63, 63) | run_bits(17, 0, 0), 1, 0, 2, 191, 0, 320, 0, 0);
    add_vec("row_edge", run_bits(16, 63, 63) | run_bits(1, 0, 0), 1, 0, 2, 191, 0, 192, 0, 0);
    add_vec("long_trunc", run_bits(0, 20, 31), 1, 0, 1, 20, 7, 2047, 0, 0);
`ifdef CLUSTER_PACKER_SPLIT_EN
    add_vec("long_split", run_bits(0, 20, 31), 0, 0, 2, 20, 7, 28, 3, 0);
    add_vec("full_split", run_bits(0, 0, 63), 0, 0, 2, 0, 7, 8, 7, 0);
`else
    add_vec("long_split", run_bits(0, 20, 31), 0, 0, 1, 20, 7, 2047, 0, 0);
    add_vec("full_split", run_bits(0, 0, 63), 0, 0, 1, 0, 7, 2047, 0, 0);
`endif
    add_vec("full_trunc", run_bits(0, 0, 63), 1, 0, 1, 0, 7, 2047, 0, 0);
    f = '0;
    for (int i = 0; i < 10; i++) f[2*i] = 1'b1;
    add_vec("even_fwd", f, 1, 0, 8, 0, 0, 2, 0, 1);
    add_vec("even_rev", f, 1, 1, 8, 18, 0, 16, 0, 1);
    add_vec("empty", '0, 1, 0, 0, 2047, 0, 2047, 0, 0);
    add_vec("top_pad", run_bits(23, 63, 63), 1, 1, 1, 1535, 0, 2047, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_frame(vecs[i].f, vecs[i].tr, vecs[i].rv, lat);
      check({vecs[i].name, "_latency"}, lat, LAT);
      check({vecs[i].name, "_nvld"}, $countones(vld), vecs[i].nv);
      check({vecs[i].name, "_adr0"}, clusters[10:0], vecs[i].a0);
      check({vecs[i].name, "_cnt0"}, clusters[13:11], vecs[i].c0);
      check({vecs[i].name, "_adr1"}, clusters[CLW +: 11], vecs[i].a1);
      check({vecs[i].name, "_cnt1"}, clusters[CLW+11 +: 3], vecs[i].c1);
      check({vecs[i].name, "_ovf_tbl"}, ovf, vecs[i].ov);
      check_model(vecs[i].name, vecs[i].f, vecs[i].tr, vecs[i].rv);
    end

    // Outputs hold after the done pulse.
    repeat (3) @(posedge clk);
    #1;
    check("hold_done_low", done, 0);
    check_model("hold", vecs[vecs.size()-1].f, 1, 1);

    // Randomized frames built in row/key space.
    for (int n = 0; n < 40; n++) begin
      f = '0;
      nruns = $urandom_range(0, 12);
      for (int r = 0; r < nruns; r++) begin
        row = $urandom_range(0, MXROWS - 1);
        key = $urandom_range(0, MXKEYS - 1);
        len = $urandom_range(1, 14);
        for (int j = 0; j < len && key + j < int'(MXKEYS); j++)
          f[(row + ((key + j) / MXSBITS) * MXROWS) * MXSBITS + (key + j) % MXSBITS] = 1'b1;
      end
      tr = 1'($urandom_range(0, 1));
      rv = 1'($urandom_range(0, 1));
      run_frame(f, tr, rv, lat);
      check("rand_latency", lat, LAT);
      check_model("rand", f, tr, rv);
    end

    // Reset in the middle of a frame.
    run_frame(run_bits(2, 3, 6), 1, 0, lat);
    check("pre_reset_vld", vld, 8'h01);
    sbits = run_bits(3, 0, 1); valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("mid_frame_ready_low", ready, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_vld", vld, 0);
    check("midrst_clusters", clusters, reset_clusters());
    check("midrst_ovf", ovf, 0);
    check("midrst_done", done, 0);
    @(posedge clk); #3;
    rst_n = 1'b1;
    #1;
    check("midrst_ready_release", ready, 1);
    saw_done = 0;
    for (int c = 0; c < 2 * LAT; c++) begin
      @(posedge clk); #1;
      if (done) saw_done = 1;
    end
    check("midrst_no_done", saw_done, 0);
    check("midrst_clusters_hold", clusters, reset_clusters());
    run_frame(run_bits(4, 9, 9), 1, 0, lat);
    check("post_reset_latency", lat, LAT);
    check_model("post_reset", run_bits(4, 9, 9), 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
